// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port arbitration blocks.
// Holds the lock FSM state type, default packet limits and a one-hot decoder.
package noc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEF_MAX_FLITS = 16;
  localparam int DEF_CNT_W     = $clog2(DEF_MAX_FLITS + 1);
  localparam int IDX_W         = 8;

  // ORs together the indices of all set bits; exact for one-hot or zero input.
  function automatic logic [IDX_W-1:0] onehot_to_bin(input logic [255:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 256; i++) begin
      if (vec[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/one_hot_mux.sv
// AND-OR multiplexer: selects one DW-bit slice of a packed bus by a one-hot select.
// A zero select yields zero.
module one_hot_mux #(
  parameter int IN_WIDTH  = 128,
  parameter int SEL_WIDTH = 4,
  localparam int DW       = IN_WIDTH / SEL_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [DW-1:0]        out_data
);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      out_data = out_data | (in_data[i*DW +: DW] & {DW{sel[i]}});
    end
  end

endmodule

// File: rtl/wormhole_req_ctrl.sv
// Requester side of a wormhole output port: raises requests, takes the arbiter's
// one-hot grant, and holds the granted channel on the output until its tail flit leaves.
module wormhole_req_ctrl
  import noc_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_FLITS = DEF_MAX_FLITS,
  localparam int CNT_W    = $clog2(MAX_FLITS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_tail,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH-1:0]        request,
  input  logic [NUM_CH-1:0]        grant,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_tail,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        owner,
  output logic                     err_grant,
  output logic                     err_len,
  output state_e                   dbg_state,
  output logic [CNT_W-1:0]         dbg_flit_cnt,
  output logic [IDX_W-1:0]         dbg_owner_idx
);

  // Handshake: a flit moves on a cycle where out_valid && out_ready are both high;
  // the same cycle raises in_ready on the owner channel only. Upstream must keep
  // in_valid, in_tail and in_data stable on a channel until that channel sees in_ready.

  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]    flit_cnt_q, flit_cnt_d;
  logic                err_grant_q, err_grant_d;
  logic                err_len_q, err_len_d;

  logic                own_valid;
  logic                own_tail;
  logic                grant_onehot;
  logic                grant_legal;
  logic                xfer;
  logic                len_hit;
  logic [CNT_W-1:0]    cnt_inc;

  assign own_valid    = |(in_valid & owner_q);
  assign own_tail     = |(in_tail & owner_q);
  assign grant_onehot = (grant != '0) && ((grant & (grant - CH_ONE)) == '0);
  assign grant_legal  = grant_onehot && ((grant & ~in_valid) == '0);
  assign xfer         = (state_q == LOCKED) && own_valid && out_ready;
  assign len_hit      = (flit_cnt_q == CNT_W'(MAX_FLITS - 1));
  assign cnt_inc      = (flit_cnt_q == CNT_W'(MAX_FLITS)) ? flit_cnt_q : flit_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      flit_cnt_q  <= '0;
      err_grant_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      flit_cnt_q  <= flit_cnt_d;
      err_grant_q <= err_grant_d;
      err_len_q   <= err_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    flit_cnt_d  = flit_cnt_q;
    err_grant_d = err_grant_q;
    err_len_d   = err_len_q;
    case (state_q)
      IDLE: begin
        if (grant != '0) begin
          if (grant_legal) begin
            owner_d    = grant;
            flit_cnt_d = '0;
            state_d    = LOCKED;
          end else begin
            err_grant_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        // The arbiter should be silent while we hold the port.
        if (grant != '0) err_grant_d = 1'b1;
        if (xfer) begin
          flit_cnt_d = cnt_inc;
          if (own_tail) begin
            state_d = IDLE;
            owner_d = '0;
          end else if (len_hit) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
            owner_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_comb begin
    request   = '0;
    in_ready  = '0;
    out_valid = 1'b0;
    out_tail  = 1'b0;
    case (state_q)
      // Gate on reset so nothing reaches the arbiter while held in reset.
      IDLE: request = reset ? in_valid : '0;
      LOCKED: begin
        out_valid = own_valid;
        out_tail  = own_tail;
        in_ready  = owner_q & {NUM_CH{out_ready}};
      end
      default: request = '0;
    endcase
  end

  one_hot_mux #(
    .IN_WIDTH  (NUM_CH * DATA_W),
    .SEL_WIDTH (NUM_CH)
  ) u_data_mux (
    .in_data  (in_data),
    .sel      (owner_q),
    .out_data (out_data)
  );

  assign owner         = owner_q;
  assign err_grant     = err_grant_q;
  assign err_len       = err_len_q;
  assign dbg_state     = state_q;
  assign dbg_flit_cnt  = flit_cnt_q;
  assign dbg_owner_idx = onehot_to_bin(256'(owner_q));

  a_owner_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(owner_q));
  a_idle_no_valid: assert property (@(posedge clk) disable iff (!reset) (state_q == IDLE) |-> !out_valid);
  a_locked_no_req: assert property (@(posedge clk) disable iff (!reset) (state_q == LOCKED) |-> (request == '0));
  a_ready_owner: assert property (@(posedge clk) disable iff (!reset) ((in_ready & ~owner_q) == '0));

endmodule

// File: tb/tb_wormhole_req_ctrl.sv
// Bench for wormhole_req_ctrl: per-channel flit queues feed the DUT, a round-robin
// arbiter model answers requests, and a packet-level model predicts every output.
module tb_wormhole_req_ctrl;
  import noc_arb_pkg::*;

  localparam int NCH  = 4;
  localparam int DW   = 32;
  localparam int MAXF = 4;
  localparam int CW   = $clog2(MAXF + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH-1:0]    in_tail = '0;
  logic [NCH*DW-1:0] in_data = '0;
  logic [NCH-1:0]    in_ready;
  logic [NCH-1:0]    request;
  logic [NCH-1:0]    grant = '0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_tail;
  logic              out_ready = 1'b0;
  logic [NCH-1:0]    owner;
  logic              err_grant;
  logic              err_len;
  state_e            dbg_state;
  logic [CW-1:0]     dbg_flit_cnt;
  logic [IDX_W-1:0]  dbg_owner_idx;

  always #5 clk = ~clk;

  wormhole_req_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .MAX_FLITS(MAXF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_tail(in_tail), .in_data(in_data),
    .in_ready(in_ready), .request(request), .grant(grant), .out_valid(out_valid),
    .out_data(out_data), .out_tail(out_tail), .out_ready(out_ready), .owner(owner),
    .err_grant(err_grant), .err_len(err_len), .dbg_state(dbg_state),
    .dbg_flit_cnt(dbg_flit_cnt), .dbg_owner_idx(dbg_owner_idx)
  );

  // Reference model: upstream flit queues, the packet expected on the output, lock owner.
  logic [DW-1:0]  src_d [NCH][$];
  logic           src_t [NCH][$];
  logic [DW-1:0]  exp_q [$];
  int             gnt_log [$];
  int             lock_ch = -1;
  int             sent = 0;
  logic           m_errg = 1'b0;
  logic           m_errl = 1'b0;
  int             rr_last = NCH - 1;
  logic [NCH-1:0] held = '0;
  int             bubble_pct = 0;
  int             vec_cnt = 0;
  int             miscompares = 0;

  function automatic logic [NCH-1:0] rr_pick(input logic [NCH-1:0] req);
    logic [NCH-1:0] g;
    bit found;
    g = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (rr_last + k) % NCH;
      if (!found && req[c]) begin
        g[c] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int c = 0; c < NCH; c++) if (src_d[c].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic push_pkt(input int ch, input int len);
    for (int i = 0; i < len; i++) begin
      src_d[ch].push_back($urandom);
      src_t[ch].push_back(i == len - 1);
    end
  endtask

  // One clock cycle: drive inputs, answer with a grant, check all outputs, advance model.
  task automatic step(input logic rdy, input logic use_arb, input logic [NCH-1:0] gnt_ovr);
    logic [NCH-1:0] exp_req, exp_own, exp_rdy, g;
    logic exp_ov, xfer, tl, done;
    logic [DW-1:0] sb;
    state_e exp_st;
    int idx;
    @(negedge clk);
    grant = '0;
    for (int c = 0; c < NCH; c++) begin
      if (src_d[c].size() == 0) begin
        in_valid[c] = 1'b0;
        in_tail[c] = 1'b0;
        in_data[c*DW +: DW] = $urandom;
      end else begin
        in_valid[c] = held[c] || (bubble_pct == 0) || ($urandom_range(0, 99) >= bubble_pct);
        in_tail[c] = src_t[c][0];
        in_data[c*DW +: DW] = src_d[c][0];
      end
    end
    out_ready = rdy;
    #1;
    exp_req = (lock_ch < 0) ? in_valid : '0;
    vec_cnt++;
    if (request !== exp_req) begin
      miscompares++;
      $display("FAIL request: got %b expected %b", request, exp_req);
    end
    if (!use_arb) g = gnt_ovr;
    else if (lock_ch < 0) g = rr_pick(exp_req);
    else g = '0;
    grant = g;
    #1;
    exp_own = (lock_ch < 0) ? '0 : (NCH'(1) << lock_ch);
    exp_st  = (lock_ch < 0) ? IDLE : LOCKED;
    exp_ov  = (lock_ch < 0) ? 1'b0 : in_valid[lock_ch];
    exp_rdy = rdy ? exp_own : '0;
    vec_cnt++;
    if (owner !== exp_own) begin
      miscompares++;
      $display("FAIL owner: got %b expected %b", owner, exp_own);
    end
    vec_cnt++;
    if (dbg_state !== exp_st) begin
      miscompares++;
      $display("FAIL state: got %0d expected %0d", dbg_state, exp_st);
    end
    vec_cnt++;
    if (out_valid !== exp_ov) begin
      miscompares++;
      $display("FAIL out_valid: got %b expected %b", out_valid, exp_ov);
    end
    vec_cnt++;
    if (in_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
    end
    vec_cnt++;
    if (err_grant !== m_errg) begin
      miscompares++;
      $display("FAIL err_grant: got %b expected %b", err_grant, m_errg);
    end
    vec_cnt++;
    if (err_len !== m_errl) begin
      miscompares++;
      $display("FAIL err_len: got %b expected %b", err_len, m_errl);
    end
    if (lock_ch >= 0) begin
      vec_cnt++;
      if (dbg_flit_cnt !== CW'(sent)) begin
        miscompares++;
        $display("FAIL flit_cnt: got %0d expected %0d", dbg_flit_cnt, sent);
      end
      vec_cnt++;
      if (dbg_owner_idx !== IDX_W'(lock_ch)) begin
        miscompares++;
        $display("FAIL owner_idx: got %0d expected %0d", dbg_owner_idx, lock_ch);
      end
      if (exp_ov) begin
        vec_cnt++;
        if (out_data !== src_d[lock_ch][0]) begin
          miscompares++;
          $display("FAIL out_data: got %h expected %h", out_data, src_d[lock_ch][0]);
        end
        vec_cnt++;
        if (out_tail !== src_t[lock_ch][0]) begin
          miscompares++;
          $display("FAIL out_tail: got %b expected %b", out_tail, src_t[lock_ch][0]);
        end
      end
    end
    xfer = exp_ov && rdy;
    for (int c = 0; c < NCH; c++) held[c] = in_valid[c] && !(xfer && (c == lock_ch));
    if (lock_ch < 0) begin
      if (g != '0) begin
        if ($onehot(g) && ((g & ~in_valid) == '0)) begin
          idx = 0;
          for (int c = 0; c < NCH; c++) if (g[c]) idx = c;
          lock_ch = idx;
          sent = 0;
          exp_q.delete();
          done = 1'b0;
          for (int i = 0; i < src_d[idx].size(); i++) begin
            if (!done) begin
              exp_q.push_back(src_d[idx][i]);
              done = src_t[idx][i];
            end
          end
          if (use_arb) begin
            rr_last = idx;
            gnt_log.push_back(idx);
          end
        end else begin
          m_errg = 1'b1;
        end
      end
    end else begin
      if (g != '0) m_errg = 1'b1;
      if (xfer) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_order: got %h expected none", out_data);
        end else begin
          sb = exp_q.pop_front();
          if (out_data !== sb) begin
            miscompares++;
            $display("FAIL sb_order: got %h expected %h", out_data, sb);
          end
        end
        tl = src_t[lock_ch][0];
        void'(src_d[lock_ch].pop_front());
        void'(src_t[lock_ch].pop_front());
        if (sent < MAXF) sent++;
        if (tl) begin
          lock_ch = -1;
          exp_q.delete();
        end else if (sent == MAXF) begin
          m_errl = 1'b1;
          lock_ch = -1;
          exp_q.delete();
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic drain(input int rdy_pct, input int max_cycles, output int cycles);
    cycles = 0;
    while ((pending() || lock_ch >= 0) && cycles < max_cycles) begin
      step($urandom_range(0, 99) < rdy_pct, 1'b1, '0);
      cycles++;
    end
    vec_cnt++;
    if (pending() || lock_ch >= 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d cycles, required completion within %0d", cycles, max_cycles);
    end
  endtask

  // Asserts reset from wherever the caller is in the cycle; iv is driven on in_valid.
  task automatic reset_dut(input logic [NCH-1:0] iv);
    in_valid = iv;
    in_tail = iv;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    grant = '0;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({request, in_ready, owner} !== '0) begin
      miscompares++;
      $display("FAIL rst_vectors: got req=%b rdy=%b own=%b expected all 0", request, in_ready, owner);
    end
    vec_cnt++;
    if ({out_valid, out_tail, err_grant, err_len} !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_flags: got ov=%b ot=%b eg=%b el=%b expected all 0", out_valid, out_tail, err_grant, err_len);
    end
    vec_cnt++;
    if (out_data !== '0) begin
      miscompares++;
      $display("FAIL rst_out_data: got %h expected 0", out_data);
    end
    for (int c = 0; c < NCH; c++) begin
      src_d[c].delete();
      src_t[c].delete();
    end
    exp_q.delete();
    lock_ch = -1;
    sent = 0;
    m_errg = 1'b0;
    m_errl = 1'b0;
    rr_last = NCH - 1;
    held = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (request !== iv) begin
      miscompares++;
      $display("FAIL post_rst_request: got %b expected %b", request, iv);
    end
    vec_cnt++;
    if (dbg_state !== IDLE || owner !== '0) begin
      miscompares++;
      $display("FAIL post_rst_state: got st=%0d own=%b expected IDLE/0", dbg_state, owner);
    end
    in_valid = '0;
    in_tail = '0;
  endtask

  task automatic test_reset();
    reset_dut(4'hF);
  endtask

  task automatic test_single_packet();
    int cyc;
    reset_dut('0);
    push_pkt(2, 3);
    drain(100, 20, cyc);
    vec_cnt++;
    if (cyc !== 4) begin
      miscompares++;
      $display("FAIL pkt3_cycles: got %0d expected 4", cyc);
    end
    step(1'b1, 1'b1, '0);
  endtask

  task automatic test_rotation();
    int cyc;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    reset_dut('0);
    push_pkt(0, 1);
    push_pkt(0, 1);
    for (int c = 1; c < NCH; c++) push_pkt(c, 1);
    gnt_log.delete();
    drain(100, 40, cyc);
    vec_cnt++;
    if (cyc !== 10) begin
      miscompares++;
      $display("FAIL rot_cycles: got %0d expected 10", cyc);
    end
    vec_cnt++;
    if (gnt_log.size() !== 5) begin
      miscompares++;
      $display("FAIL rot_count: got %0d expected 5", gnt_log.size());
    end
    for (int i = 0; i < gnt_log.size() && i < 5; i++) begin
      vec_cnt++;
      if (gnt_log[i] !== exp_order[i]) begin
        miscompares++;
        $display("FAIL rot_order[%0d]: got %0d expected %0d", i, gnt_log[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic rdy_pat [6];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    reset_dut('0);
    push_pkt(1, 4);
    step(1'b1, 1'b1, '0);
    for (int i = 0; i < 6; i++) step(rdy_pat[i], 1'b1, '0);
    drain(100, 10, cyc);
    step(1'b1, 1'b1, '0);
  endtask

  task automatic test_bad_grant();
    int cyc;
    reset_dut('0);
    push_pkt(0, 1);
    step(1'b1, 1'b0, 4'b0011);
    step(1'b1, 1'b0, 4'b1000);
    drain(100, 10, cyc);
    step(1'b1, 1'b1, '0);
    reset_dut('0);
    push_pkt(2, 3);
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 4'b0100);
    drain(100, 10, cyc);
    step(1'b1, 1'b1, '0);
  endtask

  task automatic test_len();
    int cyc;
    reset_dut('0);
    push_pkt(2, MAXF);
    drain(100, 10, cyc);
    step(1'b1, 1'b1, '0);
    push_pkt(3, 6);
    drain(100, 30, cyc);
    vec_cnt++;
    if (cyc !== 8) begin
      miscompares++;
      $display("FAIL len_cycles: got %0d expected 8", cyc);
    end
    step(1'b1, 1'b1, '0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    reset_dut('0);
    push_pkt(1, 5);
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    @(negedge clk);
    grant = '0;
    in_valid = 4'b0010;
    in_tail[1] = src_t[1][0];
    in_data[DW +: DW] = src_d[1][0];
    out_ready = 1'b1;
    #2;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== src_d[1][0]) begin
      miscompares++;
      $display("FAIL mid_flit2: got ov=%b data=%h expected 1/%h", out_valid, out_data, src_d[1][0]);
    end
    reset_dut(4'b1010);
    push_pkt(1, 2);
    push_pkt(3, 1);
    drain(100, 20, cyc);
  endtask

  task automatic test_random();
    int cyc, ch;
    reset_dut('0);
    bubble_pct = 25;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        if (src_d[ch].size() < 8) push_pkt(ch, $urandom_range(1, 6));
      end
      step($urandom_range(0, 99) < 70, 1'b1, '0);
    end
    drain(100, 400, cyc);
    bubble_pct = 0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_rotation();
    test_backpressure();
    test_bad_grant();
    test_len();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got no completion, required finish before 500000");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
